// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its storage array.
package mem_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 32;

   typedef logic [DEF_ADDR_W-1:0] addr_t;
   typedef logic [DEF_DATA_W-1:0] data_t;

   // Value returned by a read that falls outside the implemented words
   localparam data_t RD_ERR_DATA = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W register file: asynchronous clear, one synchronous write port,
// one combinational read port. The caller keeps addresses in range.
module mem_array #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Cycle-accurate req/ack memory target: programmable read latency,
// out-of-range error pulse and saturating access counters.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int READ_LATENCY = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_count,
   output logic [CNT_W-1:0]  rd_count
);

   // Handshake: req/we/addr/wdata are sampled only on an edge where the FSM is
   // in IDLE; ack (with err) is a single-cycle pulse, and the initiator drops
   // req on the edge where it sees ack. A req still high in IDLE starts anew.

   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [2:0]      LAT_INIT = 3'(READ_LATENCY - 1);

   state_t            state;
   logic [2:0]        lat_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] cur_addr;
   logic              cur_in_range;
   logic              mem_we;
   logic [DATA_W-1:0] rd_word;

   // In IDLE the live address is used; afterwards the latched one
   assign cur_addr     = (state == IDLE) ? addr : addr_q;
   assign cur_in_range = ({1'b0, cur_addr} < DEPTH_C);
   assign mem_we       = (state == IDLE) && req && we && cur_in_range;
   assign busy         = (state != IDLE);

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (addr),
      .wdata (wdata),
      .raddr (cur_addr),
      .rdata (rd_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         addr_q   <= '0;
         ack      <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (req && we) begin
                  if (cur_in_range && (wr_count != '1)) begin
                     wr_count <= wr_count + 1'b1;
                  end
                  ack   <= 1'b1;
                  err   <= !cur_in_range;
                  state <= RESP;
               end else if (req) begin
                  addr_q  <= addr;
                  lat_cnt <= LAT_INIT;
                  if (READ_LATENCY == 1) begin
                     rdata <= cur_in_range ? rd_word : '1;
                     if (cur_in_range && (rd_count != '1)) begin
                        rd_count <= rd_count + 1'b1;
                     end
                     ack   <= 1'b1;
                     err   <= !cur_in_range;
                     state <= RESP;
                  end else begin
                     state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (lat_cnt == 3'd1) begin
                  rdata <= cur_in_range ? rd_word : '1;
                  if (cur_in_range && (rd_count != '1)) begin
                     rd_count <= rd_count + 1'b1;
                  end
                  ack   <= 1'b1;
                  err   <= !cur_in_range;
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (default, DEPTH=20, CNT_W=2) share one
// initiator; table vectors plus hand-written multi-cycle sequences.
module tb_mem_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       we = 1'b0;
   logic [4:0] addr = '0;
   logic [7:0] wdata = '0;

   logic [2:0] ack_v;
   logic [2:0] err_v;
   logic [2:0] busy_v;
   logic [7:0] rdata_v [3];
   logic [15:0] wr_c0, rd_c0, wr_c1, rd_c1;
   logic [1:0]  wr_c2, rd_c2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_responder u_dut0 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack_v[0]), .err(err_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]),
      .wr_count(wr_c0), .rd_count(rd_c0)
   );

   mem_responder #(.DEPTH(20)) u_dut1 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack_v[1]), .err(err_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]),
      .wr_count(wr_c1), .rd_count(rd_c1)
   );

   mem_responder #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack_v[2]), .err(err_v[2]), .rdata(rdata_v[2]), .busy(busy_v[2]),
      .wr_count(wr_c2), .rd_count(rd_c2)
   );

   typedef struct {
      logic       w;
      logic [4:0] a;
      logic [7:0] d;
      logic [7:0] exp_rdata;
      int         exp_lat;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one transaction; lat counts edges from the sampling edge to ack
   task automatic xact(input logic w, input logic [4:0] a, input logic [7:0] d,
                       input bit hold, output int lat);
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      lat   = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ack_v[0] && lat < 16);
      if (!hold) req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;

      // Reset state
      do_reset();
      check("rst_ack", {29'd0, ack_v}, 32'd0);
      check("rst_busy", {29'd0, busy_v}, 32'd0);
      check("rst_rdata", rdata_v[0], 8'h00);
      check("rst_wr_count", wr_c0, 16'd0);
      check("rst_rd_count", rd_c0, 16'd0);

      // Reset mid-read drops the transaction and clears memory
      xact(1'b1, 5'd3, 8'h55, 1'b0, lat);
      check("pre_rst_wr_count", wr_c0, 16'd1);
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; addr = 5'd3;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrd_ack", {31'd0, ack_v[0]}, 32'd0);
      check("midrd_busy", {31'd0, busy_v[0]}, 32'd0);
      check("midrd_rdata", rdata_v[0], 8'h00);
      check("midrd_wr_count", wr_c0, 16'd0);
      @(posedge clk); #1;
      check("midrd_ack_hold", {31'd0, ack_v[0]}, 32'd0);
      req = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      xact(1'b0, 5'd3, 8'h00, 1'b0, lat);
      check("post_rst_rd3", rdata_v[0], 8'h00);
      check("post_rst_rd_lat", lat, 2);

      // Table: clear 0..4, write data=addr, read back
      for (int i = 0; i < 5; i++) begin
         vecs[i]    = '{1'b1, 5'(i), 8'h00, 8'h00, 1};
         vecs[i+5]  = '{1'b1, 5'(i), 8'(i), 8'h00, 1};
         vecs[i+10] = '{1'b0, 5'(i), 8'h00, 8'(i), 2};
      end
      do_reset();
      for (int i = 0; i < 15; i++) begin
         xact(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, lat);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_err", i), {31'd0, err_v[0]}, 32'd0);
         if (!vecs[i].w) check($sformatf("vec%0d_rdata", i), rdata_v[0], vecs[i].exp_rdata);
         @(posedge clk); #1;
         check($sformatf("vec%0d_ack_pulse", i), {31'd0, ack_v[0]}, 32'd0);
      end
      check("tbl_wr_count", wr_c0, 16'd10);
      check("tbl_rd_count", rd_c0, 16'd5);
      check("tbl_wr_count_sat", {30'd0, wr_c2}, 32'd3);
      check("tbl_rd_count_sat", {30'd0, rd_c2}, 32'd3);

      // Back-to-back write then read of addr 31 with req held high
      do_reset();
      xact(1'b1, 5'd31, 8'hA5, 1'b1, lat);
      check("b2b_wr_lat", lat, 1);
      check("b2b_busy_resp", {31'd0, busy_v[0]}, 32'd1);
      we = 1'b0;
      @(posedge clk); #1;
      check("b2b_busy_gap", {31'd0, busy_v[0]}, 32'd0);
      check("b2b_req_held", {31'd0, req}, 32'd1);
      xact(1'b0, 5'd31, 8'h00, 1'b0, lat);
      check("b2b_rd_lat", lat, 2);
      check("b2b_rdata", rdata_v[0], 8'hA5);

      // Out-of-range access on the DEPTH=20 instance
      do_reset();
      xact(1'b1, 5'd25, 8'h11, 1'b0, lat);
      check("oor_wr_err", {29'd0, err_v}, 32'b010);
      @(posedge clk); #1;
      xact(1'b0, 5'd25, 8'h00, 1'b0, lat);
      check("oor_rd_err", {29'd0, err_v}, 32'b010);
      check("oor_rd_lat", lat, 2);
      check("oor_rdata", rdata_v[1], 8'hFF);
      check("inr_rdata", rdata_v[0], 8'h11);
      check("oor_wr_count", wr_c1, 16'd0);
      check("oor_rd_count", rd_c1, 16'd0);
      @(posedge clk); #1;
      xact(1'b0, 5'd9, 8'h00, 1'b0, lat);
      check("oor_no_alias", rdata_v[1], 8'h00);
      @(posedge clk); #1;
      xact(1'b1, 5'd1, 8'h77, 1'b0, lat);
      check("rdata_held_wr", rdata_v[0], 8'h00);
      check("rdata_held_oor", rdata_v[1], 8'h00);

      // Inputs changed while busy are ignored
      do_reset();
      xact(1'b1, 5'd2, 8'h33, 1'b0, lat);
      addr = 5'd7; wdata = 8'h99; we = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("busy_chg_wr_count", wr_c0, 16'd1);
      xact(1'b0, 5'd7, 8'h00, 1'b0, lat);
      check("busy_chg_mem7", rdata_v[0], 8'h00);
      @(posedge clk); #1;
      xact(1'b0, 5'd2, 8'h00, 1'b0, lat);
      check("busy_chg_mem2", rdata_v[0], 8'h33);

      // Counter saturation with CNT_W=2
      do_reset();
      for (int i = 0; i < 6; i++) begin
         xact(1'b1, 5'(i), 8'(i + 16), 1'b0, lat);
         @(posedge clk); #1;
         if (i == 2) check("sat_wr3", {30'd0, wr_c2}, 32'd3);
      end
      check("sat_wr6", {30'd0, wr_c2}, 32'd3);
      check("nosat_wr6", wr_c0, 16'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
